// File: rtl/lc3b_types.sv
// Shared LC-3b physical-memory types and the pmem arbiter state encoding.
package lc3b_types;

    typedef logic [127:0] lc3b_pmem_line;
    typedef logic [15:0]  lc3b_pmem_addr;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } arb_state_t;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping modulo NUM_CH.
module rr_picker #(
    parameter int NUM_CH = 2,
    parameter int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [IDX_W-1:0]  ptr,
    output logic              valid,
    output logic [IDX_W-1:0]  index
);

    int unsigned cand;

    always_comb begin
        valid = 1'b0;
        index = '0;
        cand  = 0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            cand = (32'(ptr) + i) % NUM_CH;
            if (!valid && req[cand]) begin
                valid = 1'b1;
                index = cand[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/pmem_arbiter.sv
// Round-robin arbiter sharing one physical memory port among NUM_CH cache channels.
module pmem_arbiter
    import lc3b_types::*;
#(
    parameter int NUM_CH = 2,
    parameter int LINE_W = 128,
    parameter int ADDR_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH-1:0]        ch_read,
    input  logic [NUM_CH-1:0]        ch_write,
    input  logic [NUM_CH*ADDR_W-1:0] ch_address,
    input  logic [NUM_CH*LINE_W-1:0] ch_wdata,
    output logic [NUM_CH-1:0]        ch_resp,
    output logic [LINE_W-1:0]        ch_rdata,
    output logic                     pmem_read,
    output logic                     pmem_write,
    output logic [ADDR_W-1:0]        pmem_address,
    output logic [LINE_W-1:0]        pmem_wdata,
    input  logic                     pmem_resp,
    input  logic [LINE_W-1:0]        pmem_rdata
);

    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    arb_state_t          state;
    logic [IDX_W-1:0]    rr_ptr;
    logic [IDX_W-1:0]    grant;
    logic                op_write;
    logic [ADDR_W-1:0]   lat_addr;
    logic [LINE_W-1:0]   lat_wdata;

    logic                pick_valid;
    logic [IDX_W-1:0]    pick_index;
    logic                sel_write;
    logic [ADDR_W-1:0]   sel_addr;
    logic [LINE_W-1:0]   sel_wdata;

    rr_picker #(
        .NUM_CH (NUM_CH),
        .IDX_W  (IDX_W)
    ) u_picker (
        .req   (ch_read | ch_write),
        .ptr   (rr_ptr),
        .valid (pick_valid),
        .index (pick_index)
    );

    // Constant-index mux keeps part-selects static; write wins when both strobes are set.
    always_comb begin
        sel_write = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (pick_index == IDX_W'(i)) begin
                sel_write = ch_write[i];
                sel_addr  = ch_address[i*ADDR_W +: ADDR_W];
                sel_wdata = ch_wdata[i*LINE_W +: LINE_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            grant     <= '0;
            op_write  <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        grant     <= pick_index;
                        op_write  <= sel_write;
                        lat_addr  <= sel_addr;
                        lat_wdata <= sel_wdata;
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    if (pmem_resp)
                        state <= DONE;
                end
                DONE: begin
                    rr_ptr <= (grant == IDX_W'(NUM_CH - 1)) ? '0 : grant + 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign pmem_read    = (state == BUSY) && !op_write;
    assign pmem_write   = (state == BUSY) &&  op_write;
    assign pmem_address = lat_addr;
    assign pmem_wdata   = lat_wdata;
    assign ch_rdata     = pmem_rdata;

    always_comb begin
        ch_resp = '0;
        if (state == BUSY && pmem_resp)
            ch_resp[grant] = 1'b1;
    end

endmodule

// File: tb/tb_pmem_arbiter.sv
// Directed bench for pmem_arbiter: a 2-channel instance and a 4-channel round-robin instance.
module tb_pmem_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;

    // 2-channel DUT
    logic [1:0]   ch_read2, ch_write2, ch_resp2;
    logic [31:0]  ch_address2;
    logic [255:0] ch_wdata2;
    logic [127:0] ch_rdata2, pmem_wdata2, pmem_rdata2;
    logic         pmem_read2, pmem_write2, pmem_resp2;
    logic [15:0]  pmem_address2;

    // 4-channel DUT
    logic [3:0]   ch_read4, ch_write4, ch_resp4;
    logic [63:0]  ch_address4;
    logic [511:0] ch_wdata4;
    logic [127:0] ch_rdata4, pmem_wdata4, pmem_rdata4;
    logic         pmem_read4, pmem_write4, pmem_resp4;
    logic [15:0]  pmem_address4;

    pmem_arbiter dut2 (
        .clk(clk), .rst(rst),
        .ch_read(ch_read2), .ch_write(ch_write2),
        .ch_address(ch_address2), .ch_wdata(ch_wdata2),
        .ch_resp(ch_resp2), .ch_rdata(ch_rdata2),
        .pmem_read(pmem_read2), .pmem_write(pmem_write2),
        .pmem_address(pmem_address2), .pmem_wdata(pmem_wdata2),
        .pmem_resp(pmem_resp2), .pmem_rdata(pmem_rdata2)
    );

    pmem_arbiter #(.NUM_CH(4)) dut4 (
        .clk(clk), .rst(rst),
        .ch_read(ch_read4), .ch_write(ch_write4),
        .ch_address(ch_address4), .ch_wdata(ch_wdata4),
        .ch_resp(ch_resp4), .ch_rdata(ch_rdata4),
        .pmem_read(pmem_read4), .pmem_write(pmem_write4),
        .pmem_address(pmem_address4), .pmem_wdata(pmem_wdata4),
        .pmem_resp(pmem_resp4), .pmem_rdata(pmem_rdata4)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk_strobes2(input string tag, input logic rd, input logic wr, input logic [1:0] resp);
        chk({tag, "_rd"},   128'(pmem_read2),  128'(rd));
        chk({tag, "_wr"},   128'(pmem_write2), 128'(wr));
        chk({tag, "_resp"}, 128'(ch_resp2),    128'(resp));
    endtask

    initial begin
        logic [127:0] a5_line;
        logic [127:0] beef_line;
        logic [127:0] c3_line;
        int           w;

        a5_line   = {16{8'hA5}};
        beef_line = {8{16'hBEEF}};
        c3_line   = {16{8'hC3}};

        ch_read2 = '0; ch_write2 = '0; ch_address2 = '0; ch_wdata2 = '0;
        pmem_resp2 = 1'b0; pmem_rdata2 = '0;
        ch_read4 = '0; ch_write4 = '0; ch_address4 = '0; ch_wdata4 = '0;
        pmem_resp4 = 1'b0; pmem_rdata4 = '0;

        // Reset state
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        #1;
        chk_strobes2("reset", 1'b0, 1'b0, 2'b00);
        chk("reset_addr",  128'(pmem_address2), 128'(16'h0000));
        chk("reset_wdata", pmem_wdata2, 128'(0));

        // ch0 read 0x1230, resp after 3 BUSY cycles
        tick();
        ch_read2 = 2'b01; ch_address2[15:0] = 16'h1230;
        #1;
        chk_strobes2("t1_c0", 1'b0, 1'b0, 2'b00);
        for (int c = 1; c <= 3; c++) begin
            tick(); #1;
            chk_strobes2("t1_busy", 1'b1, 1'b0, 2'b00);
            chk("t1_addr", 128'(pmem_address2), 128'(16'h1230));
        end
        tick();
        pmem_resp2 = 1'b1; pmem_rdata2 = a5_line;
        #1;
        chk_strobes2("t1_c4", 1'b1, 1'b0, 2'b01);
        chk("t1_rdata", ch_rdata2, a5_line);
        tick();
        ch_read2 = 2'b00;   // pmem_resp left high in DONE: must be ignored
        #1;
        chk_strobes2("t1_done", 1'b0, 1'b0, 2'b00);
        chk("t1_rdata_pass", ch_rdata2, a5_line);
        tick(); #1;         // IDLE, no requests, stray pmem_resp
        chk_strobes2("t1_idle", 1'b0, 1'b0, 2'b00);
        chk("t1_addr_hold", 128'(pmem_address2), 128'(16'h1230));
        pmem_resp2 = 1'b0;

        // ch0 read and ch1 write same cycle, rr_ptr=0 after reset
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ch_read2 = 2'b01; ch_address2[15:0] = 16'h1000;
        ch_write2 = 2'b10; ch_address2[31:16] = 16'h2000; ch_wdata2[255:128] = beef_line;
        tick(); #1;
        chk_strobes2("t2_b0", 1'b1, 1'b0, 2'b00);
        chk("t2_addr0", 128'(pmem_address2), 128'(16'h1000));
        pmem_resp2 = 1'b1; pmem_rdata2 = c3_line;
        #1;
        chk_strobes2("t2_r0", 1'b1, 1'b0, 2'b01);
        tick();
        pmem_resp2 = 1'b0; ch_read2 = 2'b00;
        #1;
        chk_strobes2("t2_done", 1'b0, 1'b0, 2'b00);
        tick(); #1;
        chk_strobes2("t2_idle", 1'b0, 1'b0, 2'b00);
        tick(); #1;
        chk_strobes2("t2_b1", 1'b0, 1'b1, 2'b00);
        chk("t2_addr1",  128'(pmem_address2), 128'(16'h2000));
        chk("t2_wdata1", pmem_wdata2, beef_line);
        pmem_resp2 = 1'b1;
        #1;
        chk_strobes2("t2_r1", 1'b0, 1'b1, 2'b10);
        tick();
        pmem_resp2 = 1'b0; ch_write2 = 2'b00;
        tick();             // IDLE; rr_ptr back to 0

        // ch1 address changes mid-BUSY
        ch_read2 = 2'b10; ch_address2[31:16] = 16'h0040;
        tick(); #1;
        chk_strobes2("t3_b0", 1'b1, 1'b0, 2'b00);
        chk("t3_addr_a", 128'(pmem_address2), 128'(16'h0040));
        ch_address2[31:16] = 16'h0080;
        tick(); #1;
        chk("t3_addr_b", 128'(pmem_address2), 128'(16'h0040));
        tick();
        pmem_resp2 = 1'b1;
        #1;
        chk_strobes2("t3_r", 1'b1, 1'b0, 2'b10);
        chk("t3_addr_c", 128'(pmem_address2), 128'(16'h0040));
        tick();
        pmem_resp2 = 1'b0; ch_read2 = 2'b00;
        tick(); #1;
        chk("t3_addr_idle", 128'(pmem_address2), 128'(16'h0040));

        // ch0 read+write both set -> write only (rr_ptr=0)
        ch_read2 = 2'b01; ch_write2 = 2'b01;
        ch_address2[15:0] = 16'h3330; ch_wdata2[127:0] = a5_line;
        tick(); #1;
        chk_strobes2("t4_b", 1'b0, 1'b1, 2'b00);
        chk("t4_wdata", pmem_wdata2, a5_line);
        pmem_resp2 = 1'b1;
        #1;
        chk_strobes2("t4_r", 1'b0, 1'b1, 2'b01);
        tick();
        pmem_resp2 = 1'b0; ch_read2 = 2'b00; ch_write2 = 2'b00;
        tick();             // IDLE; rr_ptr=1

        // Reset in 2nd BUSY cycle; both channels request, ch1 wins first
        ch_read2 = 2'b11; ch_address2 = {16'h5550, 16'h4440};
        tick(); #1;
        chk_strobes2("t5_b0", 1'b1, 1'b0, 2'b00);
        chk("t5_addr_ch1", 128'(pmem_address2), 128'(16'h5550));
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0; pmem_resp2 = 1'b1;
        #1;
        chk_strobes2("t5_after_rst", 1'b0, 1'b0, 2'b00);
        chk("t5_addr_rst", 128'(pmem_address2), 128'(16'h0000));
        pmem_resp2 = 1'b0;
        tick(); #1;
        chk_strobes2("t5_regrant", 1'b1, 1'b0, 2'b00);
        chk("t5_addr_ch0", 128'(pmem_address2), 128'(16'h4440));
        pmem_resp2 = 1'b1;
        #1;
        chk_strobes2("t5_r", 1'b1, 1'b0, 2'b01);
        tick();
        pmem_resp2 = 1'b0; ch_read2 = 2'b00;

        // NUM_CH=4 round-robin, all channels continuously requesting
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ch_read4 = 4'b1111;
        ch_address4 = {16'h0300, 16'h0200, 16'h0100, 16'h0000};
        for (int t = 0; t < 8; t++) begin
            w = 0;
            #1;
            while (!pmem_read4 && w < 10) begin
                tick(); #1;
                w++;
            end
            chk("rr4_strobe", 128'(pmem_read4), 128'(1));
            pmem_resp4 = 1'b1;
            #1;
            chk("rr4_resp", 128'(ch_resp4), 128'(1) << (t % 4));
            chk("rr4_addr", 128'(pmem_address4), 128'(256 * (t % 4)));
            tick();
            pmem_resp4 = 1'b0;
        end
        ch_read4 = '0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/pmem_arbiter.md
PMEM_ARBITER -- requirements
Module: pmem_arbiter

Interface
REQ-001 SHALL take parameter NUM_CH, default 2: number of requesting cache channels, range 2..8.
REQ-002 SHALL take parameter LINE_W, default 128: physical line width in bits.
REQ-003 SHALL take parameter ADDR_W, default 16: physical address width in bits.
REQ-004 SHALL have port clk  in  1  the single clock; every register updates on its rising edge.
REQ-005 SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-006 SHALL have port ch_read  in  NUM_CH  per-channel line read request.
REQ-007 SHALL have port ch_write  in  NUM_CH  per-channel line write request.
REQ-008 SHALL have port ch_address  in  NUM_CH x ADDR_W  per-channel line address.
REQ-009 SHALL have port ch_wdata  in  NUM_CH x LINE_W  per-channel write line.
REQ-010 SHALL have port ch_resp  out  NUM_CH  per-channel completion pulse.
REQ-011 SHALL have port ch_rdata  out  LINE_W  read line, shared by all channels.
REQ-012 SHALL have port pmem_read  out  1  physical memory read strobe.
REQ-013 SHALL have port pmem_write  out  1  physical memory write strobe.
REQ-014 SHALL have port pmem_address  out  ADDR_W  physical memory address.
REQ-015 SHALL have port pmem_wdata  out  LINE_W  physical memory write line.
REQ-016 SHALL have port pmem_resp  in  1  physical memory completion.
REQ-017 SHALL have port pmem_rdata  in  LINE_W  physical memory read line.

Function
REQ-018 SHALL implement FSM states IDLE, BUSY and DONE.
REQ-019 In IDLE with any ch_read|ch_write set, SHALL grant by round-robin: first requesting channel at or after rr_ptr, searched with wrap-around modulo NUM_CH.
REQ-020 On grant, SHALL register the grant index, the operation, ch_address and ch_wdata, then enter BUSY; pmem_read/pmem_write SHALL be asserted from the next cycle, giving 1-cycle grant latency.
REQ-021 If a granted channel asserts both ch_read and ch_write, SHALL perform the write only.
REQ-022 In BUSY, SHALL hold pmem_read/pmem_write, pmem_address and pmem_wdata constant from the latched values until pmem_resp, ignoring changes on all channel inputs.
REQ-023 In the cycle pmem_resp=1 in BUSY, SHALL assert ch_resp[grant]=1 combinationally and drive ch_rdata=pmem_rdata; ch_resp SHALL be 0 in every other case.
REQ-024 On pmem_resp in BUSY, SHALL enter DONE; pmem_read and pmem_write SHALL be 0 in DONE.
REQ-025 In DONE, SHALL set rr_ptr=(grant+1) mod NUM_CH, issue no grant, and return to IDLE; this idle cycle lets the requester drop its strobe.
REQ-026 Back-to-back requests SHALL be spaced by a minimum of 1 DONE + 1 IDLE cycle between pmem_resp and the next pmem strobe.
REQ-027 A channel requesting continuously SHALL wait at most NUM_CH-1 transactions before it is granted.
REQ-028 pmem_resp in IDLE or DONE SHALL be ignored.
REQ-029 Outside BUSY, ch_rdata SHALL equal pmem_rdata, and pmem_address/pmem_wdata SHALL keep their last latched values.

Reset
REQ-030 With rst=1 at a clock edge, SHALL set state=IDLE, rr_ptr=0, grant=0, and latched address and wdata to 0.
REQ-031 Reset SHALL dominate all other inputs.
REQ-032 Reset in BUSY SHALL abandon the transaction: pmem_read=pmem_write=0 from the next cycle, and no ch_resp for it.

Structure
REQ-033 lc3b_types SHALL hold lc3b_pmem_line, lc3b_pmem_addr and the arbiter state enum (IDLE/BUSY/DONE).
REQ-034 Round-robin selection SHALL live in a combinational sub-module, rr_picker, with inputs req[NUM_CH] and ptr, and outputs valid and index.
REQ-035 The existing top level SHALL instantiate pmem_arbiter between the split instruction and data caches and physical memory, with NUM_CH=2.

Verification
REQ-036 Bench SHALL cover: ch0 read only, addr 0x1230, pmem_resp after 3 cycles with rdata 0xA5..A5 -> pmem_read cycles 1..4, ch_resp[0] at cycle 4 with ch_rdata 0xA5..A5, ch_resp[1] never.
REQ-037 Bench SHALL cover: ch0 read and ch1 write issued the same cycle, rr_ptr=0 -> ch0 served first, ch1 write to its latched addr/wdata next, strobes 2 cycles after first pmem_resp.
REQ-038 Bench SHALL cover: NUM_CH=4, all four channels requesting continuously for 8 transactions -> grant order 0,1,2,3,0,1,2,3.
REQ-039 Bench SHALL cover: ch1 changes ch_address 0x0040->0x0080 mid-BUSY -> pmem_address stays 0x0040 until ch_resp.
REQ-040 Bench SHALL cover: rst=1 in the 2nd BUSY cycle -> strobes 0 next cycle, no ch_resp, next grant goes to ch0.
REQ-041 Bench SHALL cover: ch0 read and write both set -> pmem_write only, pmem_read stays 0.
